// File: rtl/disp_mux4.sv
// Four-digit common-anode display multiplexer. Input patterns are shadowed at frame boundaries.
// Optional anti-ghosting blanking gap at the start of each slot: define DISP_MUX4_BLANK_GAP_EN.
module disp_mux4 #(
  parameter int REFRESH_BITS = 18,
  parameter int GAP_BITS     = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in0,
  input  logic [7:0] in1,
  input  logic [7:0] in2,
  input  logic [7:0] in3,
  input  logic [3:0] en,
  output logic [3:0] an,
  output logic [7:0] sseg,
  output logic       frame_tick
);

  localparam int SLOT_BITS = REFRESH_BITS - 2;
  localparam logic [REFRESH_BITS-1:0] Q_ONE = 1;

`ifdef DISP_MUX4_BLANK_GAP_EN
  localparam bit GAP_ON = 1'b1;
`else
  localparam bit GAP_ON = 1'b0;
`endif

  logic [REFRESH_BITS-1:0] q;
  logic                    q_max;
  logic [1:0]              sel;
  logic [SLOT_BITS-1:0]    slot_pos;
  logic                    in_gap;
  logic [7:0]              sh0, sh1, sh2, sh3;
  logic [3:0]              en_sh;
  logic [7:0]              sh_sel;
  logic [3:0]              an_nxt;
  logic [7:0]              sseg_nxt;

  assign q_max    = &q;
  assign sel      = q[REFRESH_BITS-1:REFRESH_BITS-2];
  assign slot_pos = q[SLOT_BITS-1:0];
  // Gap covers the first 2^GAP_BITS clocks of the slot; only honoured when GAP_ON.
  assign in_gap   = (slot_pos >> GAP_BITS) == '0;

  always_comb begin
    sh_sel   = 8'hFF;
    an_nxt   = 4'b1111;
    sseg_nxt = 8'hFF;
    case (sel)
      2'd0:    sh_sel = sh0;
      2'd1:    sh_sel = sh1;
      2'd2:    sh_sel = sh2;
      default: sh_sel = sh3;
    endcase
    if (en_sh[sel] && !(GAP_ON && in_gap)) begin
      an_nxt   = ~(4'b0001 << sel);
      sseg_nxt = sh_sel;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q          <= '0;
      sh0        <= 8'hFF;
      sh1        <= 8'hFF;
      sh2        <= 8'hFF;
      sh3        <= 8'hFF;
      en_sh      <= 4'b0000;
      an         <= 4'b1111;
      sseg       <= 8'hFF;
      frame_tick <= 1'b0;
    end else begin
      q          <= q + Q_ONE;
      frame_tick <= q_max;
      an         <= an_nxt;
      sseg       <= sseg_nxt;
      // Outputs above still use the old shadows on this edge; new ones take effect from q == 0.
      if (q_max) begin
        sh0   <= in0;
        sh1   <= in1;
        sh2   <= in2;
        sh3   <= in3;
        en_sh <= en;
      end
    end
  end

endmodule

// File: doc/disp_mux4.md
Name: disp_mux4

Overview:
- Downstream stage of the hex-to-seven-segment decoder.
- Takes four already-decoded 8-bit segment patterns, one per digit, and time-multiplexes them onto the Nexys 4-digit common-anode display.
- Drives one active-low anode at a time plus the shared active-low segment bus.
- Captures inputs only at frame boundaries so digits never tear mid-scan.

Parameters:
REFRESH_BITS, 18, width of the free-running refresh counter; each digit slot lasts 2^(REFRESH_BITS-2) clocks (legal: 4..32)
GAP_BITS, 4, log2 of the blanking-gap length in clocks (used only with the optional feature; must be < REFRESH_BITS-2)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
in0  input  8  segment pattern for digit 0 (rightmost); bit7=dp, bits6..0=g..a; active-low
in1  input  8  segment pattern for digit 1
in2  input  8  segment pattern for digit 2
in3  input  8  segment pattern for digit 3 (leftmost)
en  input  4  per-digit enable; en[i]=0 keeps digit i dark
an  output  4  anode drive, active-low, at most one bit low
sseg  output  8  segment drive, active-low, same bit order as inputs
frame_tick  output  1  one-clock pulse at each frame boundary (inputs captured)

Behaviour:
- Clocking: one clock, clk. Reset is synchronous, active-high, named reset; sampled on the rising edge of clk only.
- Refresh counter q:
  - REFRESH_BITS wide, reset 0, increments by 1 every clk, wraps max->0 with no stall.
  - Slot select sel = q[REFRESH_BITS-1:REFRESH_BITS-2].
  - Slot order 0,1,2,3,0...
- Shadow registers sh0..sh3:
  - Reset to 8'hFF.
  - Load in0..in3 (and en into en_sh, reset 4'b0000) on the clk edge where q == max. New values are used from q == 0 onward.
  - Inputs changing at any other time have no visible effect until the next frame boundary.
- frame_tick: registered; high for exactly the one clock following the edge where q == max (i.e. while q == 0). Reset 0.
- Outputs an and sseg:
  - Registered, 1-clock latency from q. Values at cycle t+1 reflect sel and shadows at cycle t.
  - Reset values: an=4'b1111, sseg=8'hFF.
  - Active slot s with en_sh[s]=1: an = ~(4'b0001<<s), sseg = sh_s.
  - Active slot s with en_sh[s]=0: an = 4'b1111, sseg = 8'hFF.
  - Never more than one anode low; no glitch cycles between slots.
- Reset mid-operation:
  - The edge with reset=1 clears q, shadows, en_sh, an, sseg and frame_tick.
  - After reset deasserts, scanning restarts at slot 0 with blank shadows.
  - First real data appears after the first frame boundary.
- Reset has priority over the q == max load on the same edge.
- No combinational path from inputs to outputs.

Optional Feature:
- Macro: DISP_MUX4_BLANK_GAP_EN.
- Defined:
  - During the first 2^GAP_BITS clocks of every slot (q[REFRESH_BITS-3:0] < 2^GAP_BITS), the registered outputs are forced to an=4'b1111 and sseg=8'hFF. This anti-ghosting gap lets anodes discharge.
  - The gap is subject to the same 1-clock output latency.
  - Remaining slot clocks behave as normal.
- Undefined: no gap; the anode is active for the full slot; the GAP_BITS parameter is ignored.

Test Plan (REFRESH_BITS=4 → 4 clocks/slot, 16 clocks/frame):
1. Hold reset 3 clocks with in0..in3=8'h00, en=4'b1111 -> an=4'b1111, sseg=8'hFF, frame_tick=0 throughout; release and check frame_tick=1 exactly 16 clocks after reset drops (q wrap), then every 16 clocks.
2. in0=8'hC0, in1=8'hF9, in2=8'hA4, in3=8'hB0, en=4'b1111; after first frame_tick -> each for 4 clocks: an/sseg = 1110/C0, 1101/F9, 1011/A4, 0111/B0, repeating.
3. Mid-frame (q=6), change in1 to 8'h80 -> slot 1 still shows F9 this frame; shows 80 only after the next frame_tick.
4. en=4'b1010 captured at frame boundary -> slots 0 and 2 give an=4'b1111, sseg=8'hFF; slots 1 and 3 display normally.
5. Assert reset for 1 clock while slot 2 is active -> next clock an=4'b1111, sseg=8'hFF; scan restarts at slot 0 (q=0); blank until next frame_tick.
6. With DISP_MUX4_BLANK_GAP_EN, GAP_BITS=1 -> first 2 clocks of every slot show an=4'b1111, sseg=8'hFF; last 2 clocks show scenario-2 values. Without the macro, the same bench sees all 4 clocks active.
